// File: rtl/half_adder_structural_pkg.sv
// Shared constants and types for the structural half-adder slice.
package half_adder_structural_pkg;

    // Lane count used when an instance does not override WIDTH.
    localparam int unsigned HA_WIDTH_DEFAULT = 1;

    // Type of the lane-count parameter on the interface and the top level.
    typedef int unsigned lane_cnt_t;

endpackage : half_adder_structural_pkg

// File: rtl/half_adder_structural_if.sv
// Operand and result bundle for the half adder. The master side drives the
// operands and the capture qualifier. The slave side (the adder) drives both
// result paths.
interface half_adder_structural_if
    import half_adder_structural_pkg::*;
#(
    parameter lane_cnt_t WIDTH = HA_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;

    modport master (
        output a,
        output b,
        output in_valid,
        input  sum,
        input  carry,
        input  sum_q,
        input  carry_q,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output sum,
        output carry,
        output sum_q,
        output carry_q,
        output out_valid
    );

endinterface : half_adder_structural_if

// File: rtl/half_adder_structural_cell.sv
// One half-adder lane built from gate primitives only. X and Z on the inputs
// resolve the way the xor and and primitives resolve them.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    xor u_xor (sum, a, b);
    and u_and (carry, a, b);

endmodule : half_adder_cell

// File: rtl/half_adder_structural.sv
// Half adder with WIDTH independent lanes. Nothing carries from one lane into
// the next.
// The combinational outputs do not depend on the clock, the reset or in_valid,
// so they stay valid while the block is held in reset.
// The registered copy takes a snapshot whenever in_valid is high. Between
// captures it holds its last value.
module half_adder_structural
    import half_adder_structural_pkg::*;
#(
    parameter lane_cnt_t WIDTH = HA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    half_adder_structural_if.slave  bus
);

    // One gate-level cell per lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .sum   (bus.sum[i]),
            .carry (bus.carry[i])
        );
    end

    // Snapshot the lane results when in_valid is high. out_valid pulses for
    // exactly one cycle per capture. An asserted reset drops any capture that
    // is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum_q     <= '0;
            bus.carry_q   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum_q   <= bus.sum;
                bus.carry_q <= bus.carry;
            end
        end
    end

endmodule : half_adder_structural

// File: tb/tb_half_adder_structural.sv
// Directed checks on a 1-lane and a 4-lane half adder: combinational truth
// table, an exhaustive 4-lane sweep, and the registered path across reset.
module tb_half_adder_structural;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    half_adder_structural_if #(.WIDTH(1)) if1 ();
    half_adder_structural_if #(.WIDTH(4)) if4 ();

    half_adder_structural #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    half_adder_structural #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    // The clock toggles only once clk_en is set. This keeps the first checks
    // purely combinational.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Stop the run if the main sequence never reaches its summary line.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truth-table vectors for the 1-lane adder. Each entry packs {a,b,sum,carry}.
    logic [3:0] tt [5] = '{4'b00_00, 4'b01_10, 4'b10_10, 4'b11_01, 4'b00_00};

    initial begin
        logic [3:0] v;
        logic [3:0] es, ec;
        logic [1:0] lane;

        if1.a = '0; if1.b = '0; if1.in_valid = 1'b0;
        if4.a = '0; if4.b = '0; if4.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;

        // Everything registered is zero while reset is held.
        chk("rst_sum_q1",     32'(if1.sum_q),     32'd0);
        chk("rst_carry_q1",   32'(if1.carry_q),   32'd0);
        chk("rst_out_valid1", 32'(if1.out_valid), 32'd0);
        chk("rst_out_valid4", 32'(if4.out_valid), 32'd0);

        // 1-lane truth table, one time unit per step, with no clock running.
        for (int i = 0; i < 5; i++) begin
            v = tt[i];
            if1.a = v[3];
            if1.b = v[2];
            #1;
            chk("w1_sum",   32'(if1.sum),   32'(v[1]));
            chk("w1_carry", 32'(if1.carry), 32'(v[0]));
        end

        // One 4-lane vector with hand-worked results.
        if4.a = 4'b1100; if4.b = 4'b1010;
        #1;
        chk("w4_vec_sum",   32'(if4.sum),   32'h6);
        chk("w4_vec_carry", 32'(if4.carry), 32'h8);

        // All 256 operand pairs. Expected values come from lane-wise integer addition.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if4.a = 4'(ia);
                if4.b = 4'(ib);
                #1;
                for (int k = 0; k < 4; k++) begin
                    lane = 2'(((ia >> k) & 1) + ((ib >> k) & 1));
                    es[k] = lane[0];
                    ec[k] = lane[1];
                end
                chk("w4_sum",       32'(if4.sum),             32'(es));
                chk("w4_carry",     32'(if4.carry),           32'(ec));
                chk("w4_exclusive", 32'(if4.sum & if4.carry), 32'd0);
            end
        end

        // Combinational path during reset, with the registered path still at zero.
        if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        #1;
        chk("rst_comb_sum",   32'(if1.sum),       32'd0);
        chk("rst_comb_carry", 32'(if1.carry),     32'd1);
        chk("rst_sum_q",      32'(if1.sum_q),     32'd0);
        chk("rst_carry_q",    32'(if1.carry_q),   32'd0);
        chk("rst_out_valid",  32'(if1.out_valid), 32'd0);

        // Run the clock while reset is still held. A rising edge must not capture.
        clk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_edge_carry_q", 32'(if1.carry_q),   32'd0);
        chk("rst_edge_valid",   32'(if1.out_valid), 32'd0);

        // Release reset, then take the first capture.
        @(negedge clk);
        rst_n = 1'b1;
        if4.a = 4'b1100; if4.b = 4'b1010; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("cap_carry_q",   32'(if1.carry_q),   32'd1);
        chk("cap_sum_q",     32'(if1.sum_q),     32'd0);
        chk("cap_out_valid", 32'(if1.out_valid), 32'd1);
        chk("cap4_sum_q",    32'(if4.sum_q),     32'h6);
        chk("cap4_carry_q",  32'(if4.carry_q),   32'h8);

        // Drop in_valid and change the operands. The registered values must hold.
        @(negedge clk);
        if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b1;
        if4.in_valid = 1'b0; if4.a = 4'b1111; if4.b = 4'b1111;
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(if1.out_valid), 32'd0);
        chk("hold_carry_q",   32'(if1.carry_q),   32'd1);
        chk("hold_sum_q",     32'(if1.sum_q),     32'd0);
        chk("hold_comb_sum",  32'(if1.sum),       32'd1);
        chk("hold4_sum_q",    32'(if4.sum_q),     32'h6);
        chk("hold4_carry_q",  32'(if4.carry_q),   32'h8);

        // Capture again to bring out_valid back up.
        @(negedge clk);
        if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
        @(posedge clk); #1;
        chk("cap2_sum_q",     32'(if1.sum_q),     32'd1);
        chk("cap2_carry_q",   32'(if1.carry_q),   32'd0);
        chk("cap2_out_valid", 32'(if1.out_valid), 32'd1);

        // Assert reset between edges. The registers must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sum_q",     32'(if1.sum_q),     32'd0);
        chk("async_out_valid", 32'(if1.out_valid), 32'd0);
        chk("async4_sum_q",    32'(if4.sum_q),     32'd0);
        chk("async4_carry_q",  32'(if4.carry_q),   32'd0);

        // in_valid stays high through reset. The pending capture is discarded.
        @(posedge clk); #1;
        chk("rst_hold_sum_q", 32'(if1.sum_q),     32'd0);
        chk("rst_hold_valid", 32'(if1.out_valid), 32'd0);

        // The first edge after release captures again.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_sum_q",     32'(if1.sum_q),     32'd1);
        chk("rel_out_valid", 32'(if1.out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_half_adder_structural
